fir_stream_ctrl: RTL and testbench

//  Flow-control and sequencing wrapper for the 16-tap pipelined FIR core. The core always

---
 rtl/fir_stream_ctrl.sv | 148 ++++++++++++++
 tb/tb_fir_stream_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_ctrl.sv
// Flow-control and flush sequencing wrapper around a pipelined FIR core.
// Optional statistics counters are enabled by defining FIR_CTRL_STATS_EN.
module fir_stream_ctrl #(
    parameter int DATA_WIDTH     = 16,
    parameter int OUTPUT_WIDTH   = 16,
    parameter int NUM_TAPS       = 16,
    parameter int PIPELINE_DEPTH = 5,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [OUTPUT_WIDTH-1:0] m_data,
    output logic                    core_s_valid,
    output logic [DATA_WIDTH-1:0]   core_s_data,
    input  logic                    core_m_valid,
    input  logic [OUTPUT_WIDTH-1:0] core_m_data,
    input  logic                    flush_req,
    output logic                    flush_busy,
    output logic                    err
`ifdef FIR_CTRL_STATS_EN
    ,
    output logic [31:0]             stat_in_cnt,
    output logic [31:0]             stat_stall_cnt
`endif
);

    localparam int LAT = PIPELINE_DEPTH + 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;
    localparam int CW  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [PW:0]   DEPTH_OCC = (PW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_TAP  = CW'(NUM_TAPS - 1);

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_t;

    state_t                  state;
    logic [CW-1:0]           flush_cnt;
    logic [LAT-1:0]          tag_vld;
    logic [LAT-1:0]          tag_dis;
    logic [OUTPUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           inflight_kept;

    logic [PW-1:0] fifo_count;
    logic [PW:0]   occ;
    logic          empty;
    logic          full;
    logic          flush_issue;
    logic          keep_issue;
    logic          keep_beat;
    logic          misalign;
    logic          overflow;
    logic          push;
    logic          pop;
    logic          drain_done;

    // Credit counts both buffered entries and kept beats still inside the core.
    assign fifo_count  = wr_ptr - rd_ptr;
    assign occ         = {1'b0, fifo_count} + {1'b0, inflight_kept};
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign flush_issue  = (state == FLUSH);
    assign s_ready      = (state == RUN) && (occ < DEPTH_OCC);
    assign keep_issue   = s_valid && s_ready;
    assign core_s_valid = keep_issue || flush_issue;
    assign core_s_data  = flush_issue ? '0 : s_data;
    assign flush_busy   = (state != RUN);

    assign misalign  = (core_m_valid != tag_vld[LAT-1]);
    assign keep_beat = core_m_valid && tag_vld[LAT-1] && !tag_dis[LAT-1];

    assign m_valid  = !empty;
    assign m_data   = mem[rd_ptr[AW-1:0]];
    assign pop      = m_valid && m_ready;
    assign overflow = keep_beat && full && !pop;
    assign push     = keep_beat && !overflow;

    assign drain_done = ((tag_vld & tag_dis) == '0);

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            flush_cnt      <= '0;
            tag_vld        <= '0;
            tag_dis        <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            inflight_kept  <= '0;
            err            <= 1'b0;
`ifdef FIR_CTRL_STATS_EN
            stat_in_cnt    <= '0;
            stat_stall_cnt <= '0;
`endif
        end else begin
            tag_vld <= {tag_vld[LAT-2:0], core_s_valid};
            tag_dis <= {tag_dis[LAT-2:0], flush_issue};

            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);

            case ({keep_issue, keep_beat})
                2'b10:   inflight_kept <= inflight_kept + PW'(1);
                2'b01:   inflight_kept <= inflight_kept - PW'(1);
                default: inflight_kept <= inflight_kept;
            endcase

            err <= err | misalign | overflow;

            case (state)
                RUN: begin
                    if (flush_req) begin
                        state     <= FLUSH;
                        flush_cnt <= '0;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == LAST_TAP) state <= DRAIN;
                    else                       flush_cnt <= flush_cnt + CW'(1);
                end
                DRAIN: begin
                    if (drain_done) state <= RUN;
                end
                default: state <= RUN;
            endcase

`ifdef FIR_CTRL_STATS_EN
            if (keep_issue)
                stat_in_cnt <= stat_in_cnt + 32'd1;
            if (s_valid && !s_ready && state == RUN)
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
`endif
        end
    end

    // NOTE: the FIFO storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= core_m_data;
    end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Randomized bench for fir_stream_ctrl: behavioural FIR core plus a transaction-level reference model.
// Set FIR_CTRL_STATS_EN to also check the statistics counters.
module tb_fir_stream_ctrl;

    localparam int DW       = 16;
    localparam int OW       = 16;
    localparam int NT       = 16;
    localparam int PD       = 5;
    localparam int FD       = 8;
    localparam int LAT      = PD + 1;
    localparam int OUT_LAT  = LAT + 1;
    localparam int BUSY_LEN = NT + LAT + 1;

    typedef logic [15:0] hist_t [NT];
    typedef struct { int t; logic [15:0] d; } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [OW-1:0] m_data;
    logic          core_s_valid;
    logic [DW-1:0] core_s_data;
    logic          core_m_valid;
    logic [OW-1:0] core_m_data;
    logic          flush_req = 1'b0;
    logic          flush_busy;
    logic          err;
`ifdef FIR_CTRL_STATS_EN
    logic [31:0]   stat_in_cnt;
    logic [31:0]   stat_stall_cnt;
`endif

    always #5 clk = ~clk;

    fir_stream_ctrl #(
        .DATA_WIDTH(DW), .OUTPUT_WIDTH(OW), .NUM_TAPS(NT),
        .PIPELINE_DEPTH(PD), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .core_s_valid(core_s_valid), .core_s_data(core_s_data),
        .core_m_valid(core_m_valid), .core_m_data(core_m_data),
        .flush_req(flush_req), .flush_busy(flush_busy), .err(err)
`ifdef FIR_CTRL_STATS_EN
        , .stat_in_cnt(stat_in_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    function automatic int coef(input int i);
        return ((i * 29) % 61) - 30;
    endfunction

    function automatic hist_t shift_hist(input hist_t h, input logic [15:0] x);
        hist_t r;
        r[0] = x;
        for (int i = 1; i < NT; i++) r[i] = h[i-1];
        return r;
    endfunction

    function automatic logic [15:0] fir_out(input hist_t h);
        int acc = 0;
        for (int i = 0; i < NT; i++) acc += int'($signed(h[i])) * coef(i);
        return acc[15:0];
    endfunction

    // Behavioural FIR core: fixed latency LAT, ignores backpressure.
    hist_t         core_hist;
    logic [LAT-1:0] dv;
    logic [OW-1:0] dd [LAT];

    always @(posedge clk) begin
        if (rst) begin
            dv        <= '0;
            core_hist <= '{default: '0};
        end else begin
            dv    <= {dv[LAT-2:0], core_s_valid};
            dd[0] <= fir_out(shift_hist(core_hist, core_s_data));
            for (int i = 1; i < LAT; i++) dd[i] <= dd[i-1];
            if (core_s_valid) core_hist <= shift_hist(core_hist, core_s_data);
        end
    end

    assign core_m_valid = dv[LAT-1];
    assign core_m_data  = dd[LAT-1];

    // Reference model state: accepted samples, outstanding credit, flush timeline.
    hist_t ref_hist = '{default: '0};
    exp_t  exp_q[$];
    int    outstanding = 0;
    int    busy_left   = 0;
    int    cyc         = 0;
    int    ref_in      = 0;
    int    ref_stall   = 0;
    int    dut_acc     = 0;
    int    busy_cnt    = 0;
    int    zero_cnt    = 0;
    int    n_cmp       = 0;
    int    n_bad       = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic observe();
        logic exp_busy, exp_zero, exp_ready, acc, exp_csv, exp_mv;
        cyc++;
        if (rst) begin
            exp_q.delete();
            outstanding = 0;
            busy_left   = 0;
            ref_hist    = '{default: '0};
            ref_in      = 0;
            ref_stall   = 0;
            return;
        end
        exp_busy  = (busy_left > 0);
        exp_zero  = (busy_left > LAT + 1);
        exp_ready = !exp_busy && (outstanding < FD);
        acc       = s_valid && exp_ready;
        exp_csv   = acc || exp_zero;
        exp_mv    = (exp_q.size() > 0) && (exp_q[0].t + OUT_LAT <= cyc);

        check("s_ready", 32'(s_ready), 32'(exp_ready));
        check("flush_busy", 32'(flush_busy), 32'(exp_busy));
        check("core_s_valid", 32'(core_s_valid), 32'(exp_csv));
        if (exp_csv) check("core_s_data", 32'(core_s_data), exp_zero ? 32'd0 : 32'(s_data));
        check("m_valid", 32'(m_valid), 32'(exp_mv));
        if (exp_mv) check("m_data", 32'(m_data), 32'(exp_q[0].d));
        check("err", 32'(err), 32'd0);

        if (s_valid && s_ready) dut_acc++;
        if (flush_busy) busy_cnt++;
        if (flush_busy && core_s_valid) zero_cnt++;

        if (exp_mv && m_ready) begin
            void'(exp_q.pop_front());
            outstanding--;
        end
        if (acc) begin
            exp_t e;
            ref_hist = shift_hist(ref_hist, s_data);
            e.t = cyc;
            e.d = fir_out(ref_hist);
            exp_q.push_back(e);
            outstanding++;
            ref_in++;
        end
        if (s_valid && !exp_ready && !exp_busy) ref_stall++;
        if (busy_left > 0) busy_left--;
        if (flush_req && !exp_busy) begin
            busy_left = BUSY_LEN;
            ref_hist  = '{default: '0};
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic mr, input logic fr);
        s_valid   = v;
        s_data    = d;
        m_ready   = mr;
        flush_req = fr;
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle(input logic v, input logic mr);
        for (int i = 0; i < 64 && flush_busy; i++) step(v, 16'($urandom), mr, 1'b0);
        check("flush_end", 32'(flush_busy), 32'd0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
    endtask

`ifdef FIR_CTRL_STATS_EN
    task automatic check_stats();
        check("stat_in_cnt", stat_in_cnt, 32'(ref_in));
        check("stat_stall_cnt", stat_stall_cnt, 32'(ref_stall));
    endtask
`endif

    initial begin
        // Reset
        step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        rst = 1'b0;
        #0;
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_busy", 32'(flush_busy), 32'd0);

        // Full-rate streaming
        dut_acc = 0;
        for (int i = 0; i < 40; i++) step(1'b1, 16'($urandom), 1'b1, 1'b0);
        check("full_rate_accepts", 32'(dut_acc), 32'd40);
        drain(12);

        // Backpressure: exactly FD beats fit
        dut_acc = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
        check("stall_accepts", 32'(dut_acc), 32'(FD));
        check("stall_fifo_valid", 32'(m_valid), 32'd1);
        drain(12);
        check("stall_drained", 32'(m_valid), 32'd0);

        // Flush with 3 kept beats in flight, then impulse
        step(1'b1, 16'($urandom), 1'b1, 1'b0);
        step(1'b1, 16'($urandom), 1'b1, 1'b0);
        busy_cnt = 0;
        zero_cnt = 0;
        step(1'b1, 16'($urandom), 1'b1, 1'b1);
        run_idle(1'b1, 1'b1);
        check("flush_zero_beats", 32'(zero_cnt), 32'(NT));
        check("flush_busy_len", 32'(busy_cnt), 32'(BUSY_LEN));
        step(1'b1, 16'h7FFF, 1'b1, 1'b0);
        for (int i = 0; i < NT; i++) step(1'b1, 16'h0, 1'b1, 1'b0);
        drain(12);

        // Repeated flush_req during flush, downstream stalled
        for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
        busy_cnt = 0;
        zero_cnt = 0;
        step(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        run_idle(1'b0, 1'b0);
        check("reflush_zero_beats", 32'(zero_cnt), 32'(NT));
        check("reflush_busy_len", 32'(busy_cnt), 32'(BUSY_LEN));
        drain(12);

        // Random traffic with occasional flushes
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 59) == 0);
        for (int i = 0; i < 64 && flush_busy; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
        drain(16);
`ifdef FIR_CTRL_STATS_EN
        check_stats();
`endif

        // Reset with 5 entries buffered
        for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
        check("pre_rst_m_valid", 32'(m_valid), 32'd1);
        rst = 1'b1;
        step(1'b0, 16'h0, 1'b0, 1'b0);
        rst = 1'b0;
        #0;
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_s_ready", 32'(s_ready), 32'd1);
        check("mid_rst_err", 32'(err), 32'd0);
`ifdef FIR_CTRL_STATS_EN
        check_stats();
`endif
        for (int i = 0; i < 20; i++) step(1'b1, 16'($urandom), 1'b1, 1'b0);
        drain(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
